// File: rtl/can_bit_tx_pkg.sv
// Shared CAN transmit-side types: bit engine states, default stuff length, offered-bit bundle.
package can_bit_tx_pkg;

  localparam int CAN_STUFF_LEN = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } type_can_tx_state_e;

  typedef struct packed {
    logic data;
    logic last;
    logic stuff_en;
    logic nocheck;
  } type_can_txbit_s;

endpackage

// File: rtl/can_stuff_cnt.sv
// Run-length tracker for bit stuffing: counts identical transmitted bits and flags a pending stuff bit.
// Updates one clk after a load strobe; stuff_pending is combinational from the registered state.
module can_stuff_cnt
  import can_bit_tx_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic stuff_load,
  input  logic bit_load,
  input  logic bit_data,
  input  logic bit_stuff_en,
  output logic last_bit,
  output logic stuff_pending
);

  localparam logic [2:0] STUFF_MAX = 3'(STUFF_LEN);

  logic [2:0] same_cnt;
  logic       stuff_armed;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      same_cnt    <= 3'd0;
      last_bit    <= 1'b1;
      stuff_armed <= 1'b0;
    end else if (stuff_load) begin
      same_cnt    <= 3'd1;
      last_bit    <= ~last_bit;
      stuff_armed <= 1'b0;
    end else if (bit_load) begin
      if (bit_data == last_bit) begin
        same_cnt <= (same_cnt == STUFF_MAX) ? STUFF_MAX : same_cnt + 3'd1;
      end else begin
        same_cnt <= 3'd1;
      end
      last_bit    <= bit_data;
      // Armed from the bit just sent, so a stuff bit owed after the last stuffed bit still goes out.
      stuff_armed <= bit_stuff_en;
    end
  end

  assign stuff_pending = stuff_armed & (same_cnt == STUFF_MAX);

endmodule

// File: rtl/can_bit_tx.sv
// CAN transmit bit engine: drives tx_o per tx_point, inserts stuff bits, checks the line at sample_point.
// tx_o and status update 1 clk after tx_point; bits are pulled only when bit_ready_o is high.
// CAN_TX_ARB_LOSS_EN adds arb_field_i/arb_lost_o so losing arbitration is not reported as a bit error.
module can_bit_tx
  import can_bit_tx_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_point_i,
  input  logic sample_point_i,
  input  logic sampled_bit_i,
  input  logic frame_start_i,
  input  logic abort_i,
  input  logic bit_valid_i,
  input  logic bit_data_i,
  input  logic bit_last_i,
  input  logic bit_stuff_en_i,
  input  logic bit_nocheck_i,
`ifdef CAN_TX_ARB_LOSS_EN
  input  logic arb_field_i,
  output logic arb_lost_o,
`endif
  output logic bit_ready_o,
  output logic tx_o,
  output logic stuff_bit_o,
  output logic bit_err_o,
  output logic underrun_o,
  output logic busy_o
);

  type_can_tx_state_e state_q, state_d;
  type_can_txbit_s    obit;

  logic tx_q, tx_d;
  logic stuff_q, stuff_d;
  logic check_q, check_d;
  logic err_q, err_d;
  logic underrun_q, underrun_d;
  logic cnt_clr, stuff_load, bit_load;
  logic last_bit, stuff_pending;
  logic sample_chk, mismatch, arb_loss;

  assign obit = '{data: bit_data_i, last: bit_last_i, stuff_en: bit_stuff_en_i, nocheck: bit_nocheck_i};

  assign bit_ready_o = tx_point_i & (state_q == ACTIVE) & ~stuff_pending & ~abort_i;

  // Compared against the registered line value, i.e. the pre-update value on a coincident tx_point.
  assign sample_chk = sample_point_i & check_q & (state_q != IDLE);
  assign mismatch   = sample_chk & (sampled_bit_i != tx_q);

`ifdef CAN_TX_ARB_LOSS_EN
  logic arb_q;

  assign arb_loss = mismatch & tx_q & ~sampled_bit_i & arb_field_i;

  always_ff @(posedge clk) begin
    if (rst) arb_q <= 1'b0;
    else     arb_q <= arb_loss & ~abort_i;
  end

  assign arb_lost_o = arb_q;
`else
  assign arb_loss = 1'b0;
`endif

  can_stuff_cnt #(.STUFF_LEN(STUFF_LEN)) u_stuff_cnt (
    .clk           (clk),
    .rst           (rst),
    .clr           (cnt_clr),
    .stuff_load    (stuff_load),
    .bit_load      (bit_load),
    .bit_data      (obit.data),
    .bit_stuff_en  (obit.stuff_en),
    .last_bit      (last_bit),
    .stuff_pending (stuff_pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      stuff_q    <= 1'b0;
      check_q    <= 1'b0;
      err_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      stuff_q    <= stuff_d;
      check_q    <= check_d;
      err_q      <= err_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    stuff_d    = stuff_q;
    check_d    = check_q;
    err_d      = 1'b0;
    underrun_d = 1'b0;
    cnt_clr    = 1'b0;
    stuff_load = 1'b0;
    bit_load   = 1'b0;

    if (sample_chk) begin
      check_d = 1'b0;
      err_d   = mismatch & ~arb_loss;
    end

    if (abort_i) begin
      state_d = IDLE;
      tx_d    = 1'b1;
      stuff_d = 1'b0;
      check_d = 1'b0;
      err_d   = 1'b0;
      cnt_clr = 1'b1;
    end else if (arb_loss) begin
      state_d = IDLE;
      tx_d    = 1'b1;
      stuff_d = 1'b0;
      check_d = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_start_i) begin
            state_d = ACTIVE;
            cnt_clr = 1'b1;
          end
        end
        ACTIVE, FLUSH: begin
          if (tx_point_i) begin
            if (stuff_pending) begin
              tx_d       = ~last_bit;
              stuff_d    = 1'b1;
              check_d    = 1'b1;
              stuff_load = 1'b1;
            end else if (state_q == ACTIVE && bit_valid_i) begin
              tx_d     = obit.data;
              stuff_d  = 1'b0;
              check_d  = ~obit.nocheck;
              bit_load = 1'b1;
              if (obit.last) state_d = FLUSH;
            end else begin
              // Underrun in ACTIVE, or the end of the final bit time in FLUSH.
              underrun_d = (state_q == ACTIVE);
              tx_d       = 1'b1;
              stuff_d    = 1'b0;
              check_d    = 1'b0;
              state_d    = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          stuff_d = 1'b0;
          check_d = 1'b0;
        end
      endcase
    end
  end

  assign tx_o        = tx_q;
  assign stuff_bit_o = stuff_q;
  assign bit_err_o   = err_q;
  assign underrun_o  = underrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_can_bit_tx.sv
// Self-checking bench for can_bit_tx: scoreboarded line observations per tx_point, plus pulse checks.
module tb_can_bit_tx;
  import can_bit_tx_pkg::*;

  typedef struct packed {
    logic tx;
    logic stf;
    logic busy;
    logic err;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic tx_point_i, sample_point_i, sampled_bit_i, frame_start_i, abort_i;
  logic bit_valid_i, bit_data_i, bit_last_i, bit_stuff_en_i, bit_nocheck_i;
  logic bit_ready_o, tx_o, stuff_bit_o, bit_err_o, underrun_o, busy_o;
`ifdef CAN_TX_ARB_LOSS_EN
  logic arb_field_i, arb_lost_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int underrun_cnt = 0;
  int err_cnt = 0;
  int fs_at = -1;
  logic [31:0] flip_mask = '0;

  type_can_txbit_s stim_q[$];
  obs_t exp_q[$];
  obs_t obs_q[$];

  always #5 clk = ~clk;

  can_bit_tx #(.STUFF_LEN(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .tx_point_i     (tx_point_i),
    .sample_point_i (sample_point_i),
    .sampled_bit_i  (sampled_bit_i),
    .frame_start_i  (frame_start_i),
    .abort_i        (abort_i),
    .bit_valid_i    (bit_valid_i),
    .bit_data_i     (bit_data_i),
    .bit_last_i     (bit_last_i),
    .bit_stuff_en_i (bit_stuff_en_i),
    .bit_nocheck_i  (bit_nocheck_i),
`ifdef CAN_TX_ARB_LOSS_EN
    .arb_field_i    (arb_field_i),
    .arb_lost_o     (arb_lost_o),
`endif
    .bit_ready_o    (bit_ready_o),
    .tx_o           (tx_o),
    .stuff_bit_o    (stuff_bit_o),
    .bit_err_o      (bit_err_o),
    .underrun_o     (underrun_o),
    .busy_o         (busy_o)
  );

  always @(negedge clk) begin
    if (underrun_o) underrun_cnt <= underrun_cnt + 1;
    if (bit_err_o)  err_cnt <= err_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  // Frame-engine model: offers the head of stim_q at each tx_point, pops it when accepted,
  // loops the line back at the sample point (inverted where flip_mask says), records observations.
  task automatic run_points(input int n, output int consumed);
    obs_t o;
    consumed = 0;
    for (int i = 0; i < n; i++) begin
      tx_point_i  = 1'b1;
      bit_valid_i = (stim_q.size() > 0);
      if (stim_q.size() > 0) {bit_data_i, bit_last_i, bit_stuff_en_i, bit_nocheck_i} = stim_q[0];
      #1;
      if (bit_ready_o && bit_valid_i) begin
        void'(stim_q.pop_front());
        consumed++;
      end
      tick();
      tx_point_i  = 1'b0;
      bit_valid_i = 1'b0;
      o.tx   = tx_o;
      o.stf  = stuff_bit_o;
      o.busy = busy_o;
      frame_start_i = (i == fs_at);
      tick();
      frame_start_i  = 1'b0;
      sample_point_i = 1'b1;
      sampled_bit_i  = tx_o ^ flip_mask[i];
      tick();
      sample_point_i = 1'b0;
      o.err = bit_err_o;
      obs_q.push_back(o);
      tick();
    end
  endtask

  task automatic prep();
    stim_q.delete();
    exp_q.delete();
    obs_q.delete();
    fs_at = -1;
    flip_mask = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_point_i = 0; sample_point_i = 0; sampled_bit_i = 1; frame_start_i = 0; abort_i = 0;
    bit_valid_i = 0; bit_data_i = 0; bit_last_i = 0; bit_stuff_en_i = 0; bit_nocheck_i = 0;
`ifdef CAN_TX_ARB_LOSS_EN
    arb_field_i = 0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b required 1", tx_o); end
    n_cmp++; if (stuff_bit_o !== 1'b0) begin n_bad++; $display("FAIL reset_stuff: got %b required 0", stuff_bit_o); end
    n_cmp++; if (bit_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b required 0", bit_err_o); end
    n_cmp++; if (underrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b required 0", underrun_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    tx_point_i = 1'b1; bit_valid_i = 1'b1;
    #1;
    n_cmp++; if (bit_ready_o !== 1'b0) begin n_bad++; $display("FAIL idle_ready: got %b required 0", bit_ready_o); end
    tick();
    tx_point_i = 1'b0; bit_valid_i = 1'b0;
    n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL idle_tx: got %b required 1", tx_o); end
  endtask

  // Five 0s then a 1, stuffed region; a stray frame_start mid-frame must not restart the run count.
  task automatic test_stuff_zero();
    int consumed, k;
    obs_t e, o;
    prep();
    fs_at = 2;
    for (int i = 0; i < 5; i++) begin stim_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0}); exp_q.push_back(obs_t'(4'b0010)); end
    stim_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
    exp_q.push_back(obs_t'(4'b1110));
    exp_q.push_back(obs_t'(4'b1010));
    exp_q.push_back(obs_t'(4'b1000));
    start_frame();
    run_points(8, consumed);
    n_cmp++; if (consumed !== 6) begin n_bad++; $display("FAIL stuff0_consumed: got %0d required 6", consumed); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL stuff0 point %0d: tx/stf/busy/err got %b required %b", k, o, e); end
      k++;
    end
  endtask

  // Stuff bit owed after the last stuffed bit is still sent before the unstuffed last bit.
  task automatic test_stuff_last();
    int consumed, k;
    obs_t e, o;
    prep();
    for (int i = 0; i < 5; i++) begin stim_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0}); exp_q.push_back(obs_t'(4'b1010)); end
    stim_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
    exp_q.push_back(obs_t'(4'b0110));
    exp_q.push_back(obs_t'(4'b1010));
    exp_q.push_back(obs_t'(4'b1000));
    start_frame();
    run_points(8, consumed);
    n_cmp++; if (consumed !== 6) begin n_bad++; $display("FAIL stuff1_consumed: got %0d required 6", consumed); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL stuff1 point %0d: tx/stf/busy/err got %b required %b", k, o, e); end
      k++;
    end
  endtask

  // Stuff bit owed after the last frame bit is sent from FLUSH, and is checked against the line.
  task automatic test_flush_stuff();
    int consumed, k, err0;
    obs_t e, o;
    prep();
    flip_mask[5] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stim_q.push_back('{1'b0, (i == 4), 1'b1, 1'b0});
      exp_q.push_back(obs_t'(4'b0010));
    end
    exp_q.push_back(obs_t'(4'b1111));
    exp_q.push_back(obs_t'(4'b1000));
    err0 = err_cnt;
    start_frame();
    run_points(7, consumed);
    n_cmp++; if (consumed !== 5) begin n_bad++; $display("FAIL flush_consumed: got %0d required 5", consumed); end
    n_cmp++; if (err_cnt - err0 !== 1) begin n_bad++; $display("FAIL flush_err_pulses: got %0d required 1", err_cnt - err0); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL flush point %0d: tx/stf/busy/err got %b required %b", k, o, e); end
      k++;
    end
  endtask

  task automatic test_underrun();
    int consumed, k, u0;
    obs_t e, o;
    prep();
    stim_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
    stim_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
    exp_q.push_back(obs_t'(4'b1010));
    exp_q.push_back(obs_t'(4'b0010));
    exp_q.push_back(obs_t'(4'b1000));
    u0 = underrun_cnt;
    start_frame();
    run_points(3, consumed);
    n_cmp++; if (underrun_cnt - u0 !== 1) begin n_bad++; $display("FAIL underrun_pulses: got %0d required 1", underrun_cnt - u0); end
    n_cmp++; if (consumed !== 2) begin n_bad++; $display("FAIL underrun_consumed: got %0d required 2", consumed); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL underrun point %0d: tx/stf/busy/err got %b required %b", k, o, e); end
      k++;
    end
  endtask

  // Recessive driven, dominant sampled: error on a checked bit, none in the ACK slot or when idle.
  task automatic test_bit_err();
    int consumed, k, err0;
    obs_t e, o;
    prep();
    flip_mask[2:0] = 3'b111;
    stim_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
    stim_q.push_back('{1'b1, 1'b1, 1'b0, 1'b1});
    exp_q.push_back(obs_t'(4'b1011));
    exp_q.push_back(obs_t'(4'b1010));
    exp_q.push_back(obs_t'(4'b1000));
    err0 = err_cnt;
    start_frame();
    run_points(3, consumed);
    n_cmp++; if (err_cnt - err0 !== 1) begin n_bad++; $display("FAIL biterr_pulses: got %0d required 1", err_cnt - err0); end
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL biterr point %0d: tx/stf/busy/err got %b required %b", k, o, e); end
      k++;
    end
  endtask

  // Abort with a stuff bit pending, then a fresh frame of four 0s must not be stuffed.
  task automatic test_abort();
    int consumed, k;
    obs_t e, o;
    prep();
    for (int i = 0; i < 5; i++) stim_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
    start_frame();
    run_points(5, consumed);
    abort_i = 1'b1; tx_point_i = 1'b1;
    tick();
    abort_i = 1'b0; tx_point_i = 1'b0;
    n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL abort_tx: got %b required 1", tx_o); end
    n_cmp++; if (stuff_bit_o !== 1'b0) begin n_bad++; $display("FAIL abort_stuff: got %b required 0", stuff_bit_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b required 0", busy_o); end
    prep();
    for (int i = 0; i < 4; i++) begin stim_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0}); exp_q.push_back(obs_t'(4'b0010)); end
    stim_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
    exp_q.push_back(obs_t'(4'b1010));
    exp_q.push_back(obs_t'(4'b1000));
    start_frame();
    run_points(6, consumed);
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL abort_refr point %0d: tx/stf/busy/err got %b required %b", k, o, e); end
      k++;
    end
  endtask

`ifdef CAN_TX_ARB_LOSS_EN
  task automatic test_arb_loss();
    prep();
    start_frame();
    arb_field_i = 1'b1;
    tx_point_i = 1'b1; bit_valid_i = 1'b1;
    {bit_data_i, bit_last_i, bit_stuff_en_i, bit_nocheck_i} = 4'b1010;
    tick();
    tx_point_i = 1'b0; bit_valid_i = 1'b0;
    tick();
    sample_point_i = 1'b1; sampled_bit_i = 1'b0;
    tick();
    sample_point_i = 1'b0;
    n_cmp++; if (arb_lost_o !== 1'b1) begin n_bad++; $display("FAIL arb_pulse: got %b required 1", arb_lost_o); end
    n_cmp++; if (bit_err_o !== 1'b0) begin n_bad++; $display("FAIL arb_noerr: got %b required 0", bit_err_o); end
    n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL arb_tx: got %b required 1", tx_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL arb_busy: got %b required 0", busy_o); end
    tick();
    n_cmp++; if (arb_lost_o !== 1'b0) begin n_bad++; $display("FAIL arb_width: got %b required 0", arb_lost_o); end
    arb_field_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stuff_zero();
    test_stuff_last();
    test_flush_stuff();
    test_underrun();
    test_bit_err();
    test_abort();
`ifdef CAN_TX_ARB_LOSS_EN
    test_arb_loss();
`endif
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
